// File: rtl/fixed_acc_sched_pkg.sv
// Shared types and constants for the fixed-point accumulator scheduler.
// Optional performance counters are enabled with FIXED_ACC_SCHED_PERF_EN.
package fixed_acc_sched_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StAccum,
        StOutput
    } state_e;

    localparam int unsigned PerfCntWidth = 32;

    // Requester ID width, never narrower than one bit.
    function automatic int unsigned calc_id_width(input int unsigned num_req);
        return (num_req > 1) ? $clog2(num_req) : 1;
    endfunction

endpackage

// File: rtl/fixed_rr_arbiter.sv
// Combinational round-robin arbiter: searches the request vector starting at rr_ptr_i
// and returns the first active requester as one-hot and encoded grant.
module fixed_rr_arbiter
    import fixed_acc_sched_pkg::*;
#(
    parameter int unsigned NUM_REQ  = 4,
    parameter int unsigned ID_WIDTH = calc_id_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0]  req_i,
    input  logic [ID_WIDTH-1:0] rr_ptr_i,
    output logic [NUM_REQ-1:0]  gnt_o,
    output logic [ID_WIDTH-1:0] gnt_id_o,
    output logic                any_req_o
);

    // Walk offsets from the pointer; the first requesting candidate wins.
    always_comb begin
        int unsigned cand;
        gnt_o     = '0;
        gnt_id_o  = '0;
        any_req_o = 1'b0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            cand = (32'(rr_ptr_i) + i) % NUM_REQ;
            for (int unsigned j = 0; j < NUM_REQ; j++) begin
                if (!any_req_o && (j == cand) && req_i[j]) begin
                    any_req_o = 1'b1;
                    gnt_o[j]  = 1'b1;
                    gnt_id_o  = ID_WIDTH'(j);
                end
            end
        end
    end

endmodule

// File: rtl/fixed_accumulator_scheduler.sv
// Shares one sign-extending accumulator among NUM_REQ streaming requesters. A round-robin
// winner is locked for IN_DEPTH beats; the window sum is then offered with its requester ID.
// Define FIXED_ACC_SCHED_PERF_EN to add perf_windows / perf_stall_cycles counters.
module fixed_accumulator_scheduler
    import fixed_acc_sched_pkg::*;
#(
    parameter int unsigned NUM_REQ   = 4,
    parameter int unsigned IN_DEPTH  = 4,
    parameter int unsigned IN_WIDTH  = 32,
    parameter int unsigned OUT_WIDTH = $clog2(IN_DEPTH) + IN_WIDTH,
    parameter int unsigned ID_WIDTH  = calc_id_width(NUM_REQ)
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [NUM_REQ-1:0][IN_WIDTH-1:0]  data_in,
    input  logic [NUM_REQ-1:0]                data_in_valid,
    output logic [NUM_REQ-1:0]                data_in_ready,
    output logic [OUT_WIDTH-1:0]              data_out,
    output logic [ID_WIDTH-1:0]               data_out_id,
    output logic                              data_out_valid,
    input  logic                              data_out_ready
`ifdef FIXED_ACC_SCHED_PERF_EN
    ,
    output logic [PerfCntWidth-1:0]           perf_windows,
    output logic [PerfCntWidth-1:0]           perf_stall_cycles
`endif
);

    localparam int unsigned CntWidth = (IN_DEPTH > 1) ? $clog2(IN_DEPTH) : 1;

    state_e               state_q, state_d;
    logic [ID_WIDTH-1:0]  grant_q, grant_d;
    logic [NUM_REQ-1:0]   grant_oh_q, grant_oh_d;
    logic [ID_WIDTH-1:0]  rr_ptr_q, rr_ptr_d;
    logic [CntWidth-1:0]  cnt_q, cnt_d;
    logic [OUT_WIDTH-1:0] sum_q, sum_d;

    logic [NUM_REQ-1:0]   arb_gnt;
    logic [ID_WIDTH-1:0]  arb_id;
    logic                 arb_any;
    logic                 beat_valid;
    logic [OUT_WIDTH-1:0] beat_sext;

    fixed_rr_arbiter #(
        .NUM_REQ  (NUM_REQ),
        .ID_WIDTH (ID_WIDTH)
    ) u_arbiter (
        .req_i     (data_in_valid),
        .rr_ptr_i  (rr_ptr_q),
        .gnt_o     (arb_gnt),
        .gnt_id_o  (arb_id),
        .any_req_o (arb_any)
    );

    // Only the locked grantee's lane feeds the adder.
    always_comb begin
        beat_valid = data_in_valid[grant_q];
        beat_sext  = OUT_WIDTH'($signed(data_in[grant_q]));
    end

    // Next-state: arbitrate in idle, accumulate a full window, then hold the result.
    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        grant_oh_d = grant_oh_q;
        rr_ptr_d   = rr_ptr_q;
        cnt_d      = cnt_q;
        sum_d      = sum_q;
        unique case (state_q)
            StIdle: begin
                if (arb_any) begin
                    grant_d    = arb_id;
                    grant_oh_d = arb_gnt;
                    cnt_d      = '0;
                    state_d    = StAccum;
                end
            end
            StAccum: begin
                // Ready is asserted from state alone, so a valid beat is a handshake.
                if (beat_valid) begin
                    sum_d = (cnt_q == '0) ? beat_sext : sum_q + beat_sext;
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CntWidth'(IN_DEPTH - 1)) begin
                        state_d = StOutput;
                    end
                end
            end
            StOutput: begin
                if (data_out_ready) begin
                    state_d  = StIdle;
                    rr_ptr_d = (grant_q == ID_WIDTH'(NUM_REQ - 1)) ? '0 : grant_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State registers with synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            grant_q    <= '0;
            grant_oh_q <= '0;
            rr_ptr_q   <= '0;
            cnt_q      <= '0;
            sum_q      <= '0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            grant_oh_q <= grant_oh_d;
            rr_ptr_q   <= rr_ptr_d;
            cnt_q      <= cnt_d;
            sum_q      <= sum_d;
        end
    end

    // Handshake outputs decode from registered state only.
    always_comb begin
        data_in_ready  = (state_q == StAccum) ? grant_oh_q : '0;
        data_out_valid = (state_q == StOutput);
        data_out       = sum_q;
        data_out_id    = grant_q;
    end

`ifdef FIXED_ACC_SCHED_PERF_EN
    logic [PerfCntWidth-1:0] perf_windows_q, perf_stall_q;

    // Count completed result handshakes and cycles lost to either side stalling.
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_windows_q <= '0;
            perf_stall_q   <= '0;
        end else begin
            if ((state_q == StOutput) && data_out_ready) begin
                perf_windows_q <= perf_windows_q + 1'b1;
            end
            if (((state_q == StAccum) && !beat_valid) ||
                ((state_q == StOutput) && !data_out_ready)) begin
                perf_stall_q <= perf_stall_q + 1'b1;
            end
        end
    end

    always_comb begin
        perf_windows      = perf_windows_q;
        perf_stall_cycles = perf_stall_q;
    end
`endif

endmodule

// File: tb/tb_fixed_accumulator_scheduler.sv
// Directed bench for fixed_accumulator_scheduler with NUM_REQ=4, IN_DEPTH=4, IN_WIDTH=8.
module tb_fixed_accumulator_scheduler;

    logic            clk;
    logic            rst;
    logic [3:0][7:0] data_in;
    logic [3:0]      data_in_valid;
    logic [3:0]      data_in_ready;
    logic [9:0]      data_out;
    logic [1:0]      data_out_id;
    logic            data_out_valid;
    logic            data_out_ready;
`ifdef FIXED_ACC_SCHED_PERF_EN
    logic [31:0]     perf_windows;
    logic [31:0]     perf_stall_cycles;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    fixed_accumulator_scheduler #(
        .NUM_REQ   (4),
        .IN_DEPTH  (4),
        .IN_WIDTH  (8),
        .OUT_WIDTH (10)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .data_in        (data_in),
        .data_in_valid  (data_in_valid),
        .data_in_ready  (data_in_ready),
        .data_out       (data_out),
        .data_out_id    (data_out_id),
        .data_out_valid (data_out_valid),
        .data_out_ready (data_out_ready)
`ifdef FIXED_ACC_SCHED_PERF_EN
        ,
        .perf_windows      (perf_windows),
        .perf_stall_cycles (perf_stall_cycles)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive one requester alone through its window, tracking ready; returns edges to valid.
    task automatic run_window(input logic [1:0] r, input logic [31:0] beats, output int lat);
        logic [31:0] sh;
        logic        hs;
        int          k;
        sh  = beats;
        k   = 0;
        lat = 0;
        data_in[r]       = sh[7:0];
        data_in_valid[r] = 1'b1;
        while (!data_out_valid && lat < 50) begin
            hs = data_in_ready[r] & data_in_valid[r];
            tick();
            lat++;
            if (hs) begin
                k++;
                sh = sh >> 8;
                data_in[r] = sh[7:0];
                if (k >= 4) data_in_valid[r] = 1'b0;
            end
        end
        data_in_valid[r] = 1'b0;
    endtask

    initial begin
        int lat;
        int t;
        int n;
        int last;

        rst            = 1'b1;
        data_in        = '0;
        data_in_valid  = '0;
        data_out_ready = 1'b1;
        tick();
        tick();
        rst = 1'b0;

        // Reset state
        check_eq("rst_ready", 32'(data_in_ready), 32'h0);
        check_eq("rst_valid", 32'(data_out_valid), 32'h0);
        check_eq("rst_data", 32'(data_out), 32'h0);
        check_eq("rst_id", 32'(data_out_id), 32'h0);

        // Requester 0: 1+2+3+4
        run_window(2'd0, 32'h04030201, lat);
        check_eq("t1_latency", lat, 5);
        check_eq("t1_valid", 32'(data_out_valid), 32'h1);
        check_eq("t1_data", 32'(data_out), 32'd10);
        check_eq("t1_id", 32'(data_out_id), 32'd0);
        tick();
        check_eq("t1_done", 32'(data_out_valid), 32'h0);

        // Requester 3: four times -1
        run_window(2'd3, 32'hFFFFFFFF, lat);
        check_eq("t2_latency", lat, 5);
        check_eq("t2_data", 32'(data_out), 32'h3FC);
        check_eq("t2_id", 32'(data_out_id), 32'd3);
        tick();

        // All requesters continuously valid, data r+1
        data_in[0] = 8'd1;
        data_in[1] = 8'd2;
        data_in[2] = 8'd3;
        data_in[3] = 8'd4;
        data_in_valid = 4'hF;
        t    = 0;
        n    = 0;
        last = 0;
        while (n < 6 && t < 80) begin
            tick();
            t++;
            if (data_out_valid) begin
                check_eq($sformatf("t3_id%0d", n), 32'(data_out_id), n % 4);
                check_eq($sformatf("t3_sum%0d", n), 32'(data_out), 4 * (n % 4 + 1));
                if (n == 0) check_eq("t3_first", t, 5);
                else check_eq($sformatf("t3_period%0d", n), t - last, 6);
                last = t;
                n++;
            end
        end
        check_eq("t3_count", n, 6);
        data_in_valid = '0;
        tick();
        tick();
        check_eq("t3_idle", 32'(data_out_valid), 32'h0);

        // Downstream backpressure for 5 cycles: requester 2, 10+20+30+40
        data_out_ready = 1'b0;
        run_window(2'd2, 32'h281E140A, lat);
        check_eq("t4_latency", lat, 5);
        for (int i = 0; i < 5; i++) begin
            tick();
            check_eq($sformatf("t4_hold_valid%0d", i), 32'(data_out_valid), 32'h1);
            check_eq($sformatf("t4_hold_data%0d", i), 32'(data_out), 32'd100);
            check_eq($sformatf("t4_hold_id%0d", i), 32'(data_out_id), 32'd2);
            check_eq($sformatf("t4_hold_ready%0d", i), 32'(data_in_ready), 32'h0);
        end
        data_out_ready = 1'b1;
        tick();
        check_eq("t4_release", 32'(data_out_valid), 32'h0);
        tick();
        check_eq("t4_idle_ready", 32'(data_in_ready), 32'h0);

        // Requester 1 stalls mid-window while requester 2 waits (pointer is at 3)
        data_in[1] = 8'd1;
        data_in[2] = 8'd5;
        data_in_valid = 4'b0110;
        tick();
        check_eq("t5_grant", 32'(data_in_ready), 32'h2);
        tick();
        data_in[1] = 8'd2;
        tick();
        data_in_valid[1] = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_eq($sformatf("t5_stall_ready%0d", i), 32'(data_in_ready), 32'h2);
        end
        data_in_valid[1] = 1'b1;
        data_in[1] = 8'd3;
        tick();
        data_in[1] = 8'd4;
        tick();
        data_in_valid[1] = 1'b0;
        check_eq("t5_valid", 32'(data_out_valid), 32'h1);
        check_eq("t5_data", 32'(data_out), 32'd10);
        check_eq("t5_id", 32'(data_out_id), 32'd1);
        check_eq("t5_out_ready", 32'(data_in_ready), 32'h0);
        data_in_valid[2] = 1'b0;
        tick();
        tick();

        // Reset mid-window of requester 1 (pointer is at 2)
        data_in[1] = 8'd7;
        data_in_valid = 4'b0010;
        tick();
        check_eq("t6_grant", 32'(data_in_ready), 32'h2);
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        data_in[0] = 8'd1;
        data_in[1] = 8'd2;
        data_in[2] = 8'd3;
        data_in[3] = 8'd4;
        data_in_valid = 4'hF;
        check_eq("t6_rst_valid", 32'(data_out_valid), 32'h0);
        check_eq("t6_rst_ready", 32'(data_in_ready), 32'h0);
        check_eq("t6_rst_data", 32'(data_out), 32'h0);
        tick();
        check_eq("t6_regrant", 32'(data_in_ready), 32'h1);
        t = 1;
        while (!data_out_valid && t < 50) begin
            tick();
            t++;
        end
        check_eq("t6_latency", t, 5);
        check_eq("t6_id", 32'(data_out_id), 32'd0);
        check_eq("t6_data", 32'(data_out), 32'd4);
        data_in_valid = '0;
        tick();
        tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
